// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 scancode receiver
package ps2_pkg;
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_frame_state_e;
    localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK = 8'hF0;
    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;
endpackage

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: synchronous first-word-fall-through event queue
module ps2_evt_fifo #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign rdata = mem_q[rd_q];
    assign count = count_q;

    // a pop frees the slot a same-cycle push writes, so full+pop still accepts
    always_comb begin
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        wr_d    = wr_q + AW'(do_push);
        rd_d    = rd_q + AW'(do_pop);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 frame receiver with watchdog, E0/F0 prefix decoding and event FIFO
module ps2_scan_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ps2_clk,
    input  logic                        ps2_data,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_brk,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        overflow
);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    ps2_frame_state_e       state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d, data_sync_q, data_sync_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             byte_q, byte_d;
    logic                   par_q, par_d, byte_done_q, byte_done_d;
    logic                   ext_q, ext_d, brk_q, brk_d;
    logic                   err_parity_q, err_parity_d, err_frame_q, err_frame_d;
    logic                   overflow_q, overflow_d;
    logic                   fall, data, timeout, push, pop, full, empty;
    ps2_evt_t               evt, head;

    assign fall       = clk_sync_q[SYNC_STAGES-1] & ~clk_sync_q[SYNC_STAGES-2];
    assign data       = data_sync_q[SYNC_STAGES-1];
    assign pop        = evt_valid & evt_ready;
    assign evt_valid  = ~empty;
    assign evt_code   = head.code;
    assign evt_ext    = head.ext;
    assign evt_brk    = head.brk;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign overflow   = overflow_q;

    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_d       = byte_q;
        par_d        = par_q;
        wd_d         = (fall || state_q == IDLE) ? '0 : wd_q + 1'b1;
        timeout      = state_q != IDLE && !fall && wd_q == WDW'(TIMEOUT_CYC - 1);
        byte_done_d  = 1'b0;
        err_parity_d = 1'b0;
        err_frame_d  = timeout;
        if (timeout) state_d = IDLE;
        else if (fall) begin
            case (state_q)
                IDLE: begin
                    state_d     = data ? IDLE : DATA;
                    err_frame_d = data;
                    bit_cnt_d   = '0;
                end
                DATA: begin
                    byte_d    = {data, byte_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = bit_cnt_q == 3'd7 ? PARITY : DATA;
                end
                PARITY: begin
                    par_d   = data;
                    state_d = STOP;
                end
                default: begin
                    byte_done_d  = data & ^{byte_q, par_q};
                    err_frame_d  = ~data;
                    err_parity_d = data & ~^{byte_q, par_q};
                    state_d      = IDLE;
                end
            endcase
        end
        // prefixes only arm flags; any other byte is emitted and consumes them
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        evt   = {ext_q, brk_q, byte_q};
        if (byte_done_q) begin
            if (byte_q == PS2_PFX_EXT) ext_d = 1'b1;
            else if (byte_q == PS2_PFX_BRK) brk_d = 1'b1;
            else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        if (err_parity_d || err_frame_d) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        overflow_d = push & full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            wd_q         <= '0;
            bit_cnt_q    <= '0;
            byte_q       <= '0;
            par_q        <= 1'b0;
            byte_done_q  <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            err_parity_q <= 1'b0;
            err_frame_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            wd_q         <= wd_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_q       <= byte_d;
            par_q        <= par_d;
            byte_done_q  <= byte_done_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            err_parity_q <= err_parity_d;
            err_frame_q  <= err_frame_d;
            overflow_q   <= overflow_d;
        end
    end

    ps2_evt_fifo #(.WIDTH($bits(ps2_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .wdata(evt),
        .pop  (pop),
        .rdata(head),
        .full (full),
        .empty(empty),
        .count(fifo_count)
    );
endmodule
